// File: rtl/NXConstants.sv
// Shared node-network constants and message types used by every NX block.
package NXConstants;

    localparam int MESSAGE_WIDTH = 32;
    localparam int NODE_ID_WIDTH = 2;

    typedef struct packed {
        logic [NODE_ID_WIDTH-1:0] source;
        logic [5:0]               command;
        logic [23:0]              payload;
    } node_message_t;

endpackage

// File: rtl/nx_node_outbound_arbiter_pkg.sv
// Local helpers for the outbound arbiter; no shared types live here.
package nx_node_outbound_arbiter_pkg;

    // Index width that is always at least one bit wide.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Single-step wrap for an index known to lie in [0, 2n).
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/nx_node_arb_fifo.sv
// Per-source message buffer with a registered "not full" ready.
module nx_node_arb_fifo
    import NXConstants::*;
    import nx_node_outbound_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  node_message_t data_i,
    output node_message_t data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ready_o
);

    localparam int AW = idx_w(DEPTH);
    localparam int CW = AW + 1;

    node_message_t   mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q;
    logic            push_en, pop_en;

    // The push side is qualified by our own registered ready, so a full buffer never takes a write.
    assign push_en = push_i && ready_q;
    assign pop_en  = pop_i && !empty_o;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign ready_o = ready_q;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push_en && !pop_en) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_en && pop_en) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push_en) wptr_q <= wptr_q + AW'(1);
            if (pop_en)  rptr_q <= rptr_q + AW'(1);
            cnt_q   <= cnt_d;
            ready_q <= (cnt_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/nx_node_outbound_arbiter.sv
// Round-robin merge of SOURCES buffered message streams into one registered output.
module nx_node_outbound_arbiter
    import NXConstants::*;
    import nx_node_outbound_arbiter_pkg::*;
#(
    parameter int SOURCES = 2,
    parameter int DEPTH   = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    output logic                        o_idle,
    input  node_message_t [SOURCES-1:0] i_inbound_data,
    input  logic [SOURCES-1:0]          i_inbound_valid,
    output logic [SOURCES-1:0]          o_inbound_ready,
    output node_message_t               o_outbound_data,
    output logic                        o_outbound_valid,
    input  logic                        i_outbound_ready
);

    localparam int PW = idx_w(SOURCES);

    node_message_t [SOURCES-1:0] head;
    logic [SOURCES-1:0]          empty, full, pop;

    node_message_t  out_q, out_d;
    logic           out_vld_q, out_vld_d;
    logic [PW-1:0]  prio_q, prio_d;
    logic [PW-1:0]  gnt_idx;
    logic           gnt_vld;
    logic           load;

    for (genvar k = 0; k < SOURCES; k++) begin : g_src
        nx_node_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk_i   (i_clk),
            .rst_ni  (i_rst),
            .push_i  (i_inbound_valid[k]),
            .pop_i   (pop[k]),
            .data_i  (i_inbound_data[k]),
            .data_o  (head[k]),
            .full_o  (full[k]),
            .empty_o (empty[k]),
            .ready_o (o_inbound_ready[k])
        );

        assign pop[k] = load && gnt_vld && (gnt_idx == PW'(k));

        a_full_blocks_push: assert property (@(posedge i_clk) disable iff (!i_rst)
            full[k] |-> !o_inbound_ready[k]);
    end

    // The output register refills whenever it is empty or drained this cycle.
    assign load = !out_vld_q || i_outbound_ready;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < SOURCES; i++) begin
            if (!gnt_vld && !empty[rr_wrap(int'(prio_q) + i, SOURCES)]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'(rr_wrap(int'(prio_q) + i, SOURCES));
            end
        end
    end

    always_comb begin
        out_d     = out_q;
        out_vld_d = out_vld_q;
        prio_d    = prio_q;
        if (load) begin
            out_vld_d = gnt_vld;
            if (gnt_vld) begin
                out_d  = head[gnt_idx];
                prio_d = PW'(rr_wrap(int'(gnt_idx) + 1, SOURCES));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            prio_q    <= '0;
        end else begin
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            prio_q    <= prio_d;
        end
    end

    assign o_outbound_data  = out_q;
    assign o_outbound_valid = out_vld_q;
    assign o_idle           = (&empty) && !out_vld_q;

endmodule

// File: tb/tb_nx_node_outbound_arbiter.sv
// Scenario bench for the outbound arbiter against a queue-based reference model.
module tb_nx_node_outbound_arbiter;
    import NXConstants::*;

    localparam int SOURCES = 2;
    localparam int DEPTH   = 2;

    logic                        i_clk = 1'b0;
    logic                        i_rst = 1'b0;
    logic                        o_idle;
    node_message_t [SOURCES-1:0] in_data;
    logic [SOURCES-1:0]          in_valid;
    logic [SOURCES-1:0]          o_inbound_ready;
    node_message_t               o_outbound_data;
    logic                        o_outbound_valid;
    logic                        ob_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one FIFO queue per source plus a one-deep output stage.
    node_message_t      mq [SOURCES][$];
    node_message_t      m_out;
    bit                 m_vld;
    int                 m_ptr;
    logic [SOURCES-1:0] m_rdy;
    logic [SOURCES-1:0] last_acc;
    node_message_t      got [$];

    always #5 i_clk = ~i_clk;

    nx_node_outbound_arbiter #(.SOURCES(SOURCES), .DEPTH(DEPTH)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_idle           (o_idle),
        .i_inbound_data   (in_data),
        .i_inbound_valid  (in_valid),
        .o_inbound_ready  (o_inbound_ready),
        .o_outbound_data  (o_outbound_data),
        .o_outbound_valid (o_outbound_valid),
        .i_outbound_ready (ob_rdy)
    );

    function automatic node_message_t mk(input int src, input int pay);
        node_message_t m;
        m.source  = 2'(src);
        m.command = 6'(pay >> 4);
        m.payload = 24'(pay);
        return m;
    endfunction

    function automatic bit m_idle();
        bit e = 1'b1;
        for (int k = 0; k < SOURCES; k++) if (mq[k].size() != 0) e = 1'b0;
        return e && !m_vld;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < SOURCES; k++) mq[k].delete();
        m_out = '0; m_vld = 1'b0; m_ptr = 0; m_rdy = '0; last_acc = '0;
    endtask

    // One clock edge: model decisions use pre-edge state, DUT is sampled 1 time unit after.
    task automatic tick();
        int g;
        bit ld;
        logic [SOURCES-1:0] acc;
        ld = !m_vld || ob_rdy;
        if (o_outbound_valid && ob_rdy) got.push_back(o_outbound_data);
        g = -1;
        if (ld) begin
            for (int i = 0; i < SOURCES; i++) begin
                int k;
                k = (m_ptr + i) % SOURCES;
                if (g < 0 && mq[k].size() > 0) g = k;
            end
        end
        acc = in_valid & m_rdy;
        @(posedge i_clk);
        if (ld) begin
            if (g >= 0) begin
                m_out = mq[g].pop_front();
                m_vld = 1'b1;
                m_ptr = (g + 1) % SOURCES;
            end else begin
                m_vld = 1'b0;
            end
        end
        for (int k = 0; k < SOURCES; k++) begin
            if (acc[k]) mq[k].push_back(in_data[k]);
            m_rdy[k] = (mq[k].size() < DEPTH);
        end
        last_acc = acc;
        #1;
    endtask

    task automatic apply_reset();
        i_rst = 1'b0; in_valid = '0; in_data = '0; ob_rdy = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        model_clear();
        got.delete();
        i_rst = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; in_valid = '0; in_data = '0; ob_rdy = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        model_clear();
        n_tests++; if (o_outbound_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_outbound_valid); end
        n_tests++; if (o_outbound_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", o_outbound_data); end
        n_tests++; if (o_inbound_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_inbound_ready); end
        n_tests++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b want 1", o_idle); end
        i_rst = 1'b1;
        tick();
        n_tests++; if (o_inbound_ready !== '1) begin n_fail++; $display("FAIL reset_release_ready: got %b want all ones", o_inbound_ready); end
        n_tests++; if (o_idle !== 1'b1) begin n_fail++; $display("FAIL reset_release_idle: got %b want 1", o_idle); end
    endtask

    task automatic test_single();
        apply_reset(); tick();
        ob_rdy = 1'b1; in_valid = 2'b01; in_data[0] = mk(0, 'hA5);
        tick();
        in_valid = '0;
        n_tests++; if (o_outbound_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", o_outbound_valid); end
        tick();
        n_tests++; if (o_outbound_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", o_outbound_valid); end
        n_tests++; if (o_outbound_data !== mk(0, 'hA5)) begin n_fail++; $display("FAIL single_data: got %h want %h", o_outbound_data, mk(0, 'hA5)); end
        tick();
        n_tests++; if (o_outbound_valid !== 1'b0 || o_idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got valid %b idle %b want 0/1", o_outbound_valid, o_idle); end
    endtask

    task automatic test_fairness();
        int seq [SOURCES];
        int exp_pay [SOURCES];
        int bad;
        apply_reset(); tick();
        for (int k = 0; k < SOURCES; k++) begin seq[k] = 0; exp_pay[k] = 0; in_data[k] = mk(k, 0); end
        ob_rdy = 1'b1; in_valid = '1; bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int k = 0; k < SOURCES; k++) if (last_acc[k]) begin seq[k]++; in_data[k] = mk(k, seq[k]); end
            if (c >= 1) begin
                if (o_outbound_valid !== 1'b1 || int'(o_outbound_data.source) != (c - 1) % 2
                    || int'(o_outbound_data.payload) != exp_pay[(c - 1) % 2]) begin
                    bad++;
                    $display("FAIL fairness_cycle%0d: got valid %b msg %h want src %0d payload %0d",
                             c, o_outbound_valid, o_outbound_data, (c - 1) % 2, exp_pay[(c - 1) % 2]);
                end
                exp_pay[(c - 1) % 2]++;
            end
        end
        in_valid = '0;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL fairness_alternate: got %0d bad cycles want 0", bad); end
    endtask

    // Push on source 0 under a stalled output until the buffer closes; returns messages accepted.
    task automatic fill_src0(input int base, input int cycles, output int seq, output int at_fall, output int unstable);
        apply_reset(); tick();
        ob_rdy = 1'b0; in_valid = 2'b01; seq = 0; at_fall = -1; unstable = 0;
        in_data[0] = mk(0, base);
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (last_acc[0]) begin seq++; in_data[0] = mk(0, base + seq); end
            if (at_fall < 0 && o_inbound_ready[0] === 1'b0) at_fall = seq;
            if (c >= 1 && (o_outbound_valid !== 1'b1 || o_outbound_data !== mk(0, base))) unstable++;
        end
    endtask

    task automatic test_backpressure();
        int seq, at_fall, unstable;
        fill_src0('h100, 10, seq, at_fall, unstable);
        n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
        n_tests++; if (at_fall != DEPTH + 1) begin n_fail++; $display("FAIL bp_ready_fall: got fall after %0d accepted want %0d", at_fall, DEPTH + 1); end
        n_tests++; if (seq != DEPTH + 1) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", seq, DEPTH + 1); end
        in_valid = '0; ob_rdy = 1'b1;
        repeat (5) tick();
        n_tests++;
        if (got.size() != 3 || got[0] !== mk(0, 'h100) || got[1] !== mk(0, 'h101) || got[2] !== mk(0, 'h102)) begin
            n_fail++; $display("FAIL bp_release_order: got %0d msgs want 3 in order 100,101,102", got.size());
        end
    endtask

    task automatic test_full_simul();
        int seq, at_fall, unstable;
        fill_src0('h200, 4, seq, at_fall, unstable);
        n_tests++; if (o_inbound_ready[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready_low: got %b want 0", o_inbound_ready[0]); end
        ob_rdy = 1'b1;
        tick();
        n_tests++; if (o_inbound_ready[0] !== 1'b1 || last_acc[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready_rise: got ready %b acc %b want 1/0", o_inbound_ready[0], last_acc[0]); end
        tick();
        n_tests++; if (last_acc[0] !== 1'b1) begin n_fail++; $display("FAIL full_push_after_pop: got %b want 1", last_acc[0]); end
        in_valid = '0;
        repeat (5) tick();
        n_tests++;
        if (got.size() != 4 || got[0] !== mk(0, 'h200) || got[1] !== mk(0, 'h201)
            || got[2] !== mk(0, 'h202) || got[3] !== mk(0, 'h203)) begin
            n_fail++; $display("FAIL full_order: got %0d msgs want 4 in order 200..203", got.size());
        end
    endtask

    task automatic test_pointer_skip();
        apply_reset(); tick();
        ob_rdy = 1'b1; in_valid = 2'b10; in_data[1] = mk(1, 'h33);
        tick();
        in_valid = '0;
        tick();
        n_tests++; if (o_outbound_valid !== 1'b1 || o_outbound_data !== mk(1, 'h33)) begin n_fail++; $display("FAIL skip_grant: got %b %h want 1 %h", o_outbound_valid, o_outbound_data, mk(1, 'h33)); end
        in_valid = 2'b11; in_data[0] = mk(0, 'h44); in_data[1] = mk(1, 'h55);
        tick();
        in_valid = '0;
        tick();
        n_tests++; if (o_outbound_data !== mk(0, 'h44)) begin n_fail++; $display("FAIL skip_ptr_wrap: got %h want %h", o_outbound_data, mk(0, 'h44)); end
        tick();
        n_tests++; if (o_outbound_data !== mk(1, 'h55)) begin n_fail++; $display("FAIL skip_next: got %h want %h", o_outbound_data, mk(1, 'h55)); end
    endtask

    task automatic test_midstream_reset();
        int stale;
        apply_reset(); tick();
        ob_rdy = 1'b0; in_valid = 2'b11; in_data[0] = mk(0, 'h61); in_data[1] = mk(1, 'h71);
        tick();
        in_valid = 2'b01; in_data[0] = mk(0, 'h62);
        tick();
        in_valid = '0;
        #2 i_rst = 1'b0;
        #1;
        model_clear(); got.delete();
        n_tests++; if (o_outbound_valid !== 1'b0 || o_inbound_ready !== '0 || o_idle !== 1'b1) begin
            n_fail++; $display("FAIL midrst_immediate: got valid %b ready %b idle %b want 0/00/1", o_outbound_valid, o_inbound_ready, o_idle);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b1; ob_rdy = 1'b1;
        tick();
        n_tests++; if (o_inbound_ready !== '1) begin n_fail++; $display("FAIL midrst_ready: got %b want all ones", o_inbound_ready); end
        stale = 0;
        repeat (4) begin tick(); if (o_outbound_valid !== 1'b0) stale++; end
        n_tests++; if (stale != 0 || got.size() != 0) begin n_fail++; $display("FAIL midrst_stale: got %0d stale cycles %0d msgs want 0", stale, got.size()); end
    endtask

    task automatic test_random();
        apply_reset(); tick();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < SOURCES; k++) begin
                in_valid[k] = ($urandom_range(0, 2) != 0);
                in_data[k]  = mk(k, int'($urandom_range(0, 'hFFFF)));
            end
            ob_rdy = (c % 64 < 48) ? ($urandom_range(0, 3) != 0) : 1'b0;
            tick();
            n_tests++; if (o_outbound_valid !== m_vld) begin n_fail++; $display("FAIL rand_valid@%0d: got %b want %b", c, o_outbound_valid, m_vld); end
            if (m_vld) begin
                n_tests++; if (o_outbound_data !== m_out) begin n_fail++; $display("FAIL rand_data@%0d: got %h want %h", c, o_outbound_data, m_out); end
            end
            n_tests++; if (o_inbound_ready !== m_rdy) begin n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", c, o_inbound_ready, m_rdy); end
            n_tests++; if (o_idle !== m_idle()) begin n_fail++; $display("FAIL rand_idle@%0d: got %b want %b", c, o_idle, m_idle()); end
        end
    endtask

    initial begin
        in_valid = '0; in_data = '0; ob_rdy = 1'b0;
        model_clear();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_full_simul();
        test_pointer_skip();
        test_midstream_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nx_node_outbound_arbiter.md
NX_NODE_OUTBOUND_ARBITER -- requirements
Module: nx_node_outbound_arbiter

Interface
REQ-001 The block SHALL be parameterised as: SOURCES, 2, number of upstream message sources (2..4).
REQ-002 The block SHALL be parameterised as: DEPTH, 2, per-source buffer entries (power of two, >=2).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports named as below.
REQ-004 The block SHALL provide i_clk  input  1  clock, all logic rising-edge.
REQ-005 The block SHALL provide i_rst  input  1  asynchronous reset, active-low.
REQ-006 The block SHALL provide o_idle  output  1  high when all buffers are empty and no output is pending.
REQ-007 The block SHALL provide i_inbound_data  input  SOURCES x node_message_t  message per source.
REQ-008 The block SHALL provide i_inbound_valid  input  SOURCES  per-source valid.
REQ-009 The block SHALL provide o_inbound_ready  output  SOURCES  per-source ready, registered.
REQ-010 The block SHALL provide o_outbound_data  output  node_message_t  message to the node distributor.
REQ-011 The block SHALL provide o_outbound_valid  output  1  output valid.
REQ-012 The block SHALL provide i_outbound_ready  input  1  distributor ready.

Function
REQ-013 A message SHALL be accepted from source k on a rising edge where i_inbound_valid[k] and o_inbound_ready[k] are both high, and written to buffer k in arrival order.
REQ-014 o_inbound_ready[k] SHALL be a register equal to "buffer k not full" after the edge, so a push is never accepted into a full buffer.
REQ-015 A simultaneous push and pop on buffer k SHALL keep its occupancy unchanged, and this SHALL be legal at any occupancy, including full (ready stays low when full).
REQ-016 The output stage SHALL be a single register, loaded when it is empty or when it is being consumed (o_outbound_valid & i_outbound_ready) on the same edge, sustaining 1 message per cycle.
REQ-017 When the output stage loads, the arbiter SHALL grant the first non-empty buffer found scanning from the priority pointer upward, modulo SOURCES, and pop that buffer.
REQ-018 After a grant to source k, the priority pointer SHALL become (k+1) mod SOURCES; without a grant the pointer SHALL hold.
REQ-019 While o_outbound_valid is high and i_outbound_ready is low, o_outbound_data and o_outbound_valid SHALL hold stable.
REQ-020 Minimum latency SHALL be 2 cycles: a message accepted at edge N appears on o_outbound_valid/data after edge N+1.
REQ-021 Message content SHALL pass through unmodified, with no reordering within a single source.
REQ-022 o_idle SHALL be a combinational AND of all buffers empty and !o_outbound_valid.
REQ-023 Buffer pointers SHALL wrap modulo DEPTH, and occupancy SHALL be held in clog2(DEPTH)+1 bits.

Reset
REQ-024 While i_rst is low, the block SHALL hold: o_outbound_valid=0, o_outbound_data=0, o_inbound_ready=0, all buffers empty, priority pointer=0, o_idle=1.
REQ-025 On the first edge after i_rst rises, o_inbound_ready SHALL become all-ones.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered and pending messages immediately, with no partial output.

Structure
REQ-027 node_message_t, MESSAGE_WIDTH and related message typedefs SHALL come from the shared NXConstants package, and the block SHALL define no new shared types.
REQ-028 The per-source buffer SHALL be one sub-module, nx_node_arb_fifo (parameter DEPTH, push/pop/full/empty), instantiated SOURCES times.
REQ-029 The arbiter and output register SHALL live in the top module.

Verification
REQ-030 The bench SHALL cover single message: source 0 pushes 0xA5 payload at edge 1 with i_outbound_ready=1 -> o_outbound_valid high after edge 2 with identical data, then o_idle=1 after it is consumed.
REQ-031 The bench SHALL cover fairness: both sources stream continuously with ready=1 -> outputs alternate S0,S1,S0,S1 at 1 msg/cycle.
REQ-032 The bench SHALL cover backpressure: i_outbound_ready=0 for 10 cycles while source 0 pushes -> output data stable throughout, o_inbound_ready[0] falls after DEPTH+1=3 accepted, and no loss on release.
REQ-033 The bench SHALL cover full plus simultaneous pop/push: buffer 0 full, ready=1, source 0 valid -> ready[0] rises one cycle after the pop, and order is preserved.
REQ-034 The bench SHALL cover pointer skip: only source 1 is active, with the pointer at 0 -> grant goes to 1 and the pointer becomes 0.
REQ-035 The bench SHALL cover mid-stream reset: i_rst pulsed low with 3 messages buffered -> valid=0, ready=0 and idle=1 immediately, ready=1 one edge after release, and no stale message is emitted.
